// File: rtl/quad_packet_sched.sv
// Packet-transfer sequencer for the MCU SPI receiver: synchronises load/done, watchdogs RECV and
// buffers captured quad packets in a FIFO. Define QUAD_ZERO_DROP_EN to discard all-zero captures.
module quad_packet_sched #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PKT_W          = 92
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_in,
  input  logic             done_in,
  input  logic [PKT_W-1:0] pkt_in,
  output logic             quad_valid,
  input  logic             quad_ready,
  output logic [PKT_W-1:0] quad_data,
  output logic             busy,
  output logic             overflow,
  output logic             timeout,
  output logic [7:0]       pkt_count,
`ifdef QUAD_ZERO_DROP_EN
  output logic             zero_drop,
`endif
  input  logic             clr_status
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_CAPTURE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       load_sync_q, done_sync_q;
  logic             load_rise, load_fall, done_rise;
  logic [WW-1:0]    wd_q, wd_d;
  logic             capture, tmo_set;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PKT_W-1:0] head_q, head_d;
  logic             push, pop, full, drop, zero_pkt;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;
  logic [7:0]       cnt_q, cnt_d;

  // Two flops for metastability, the third only for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_sync_q <= '0;
      done_sync_q <= '0;
    end else begin
      load_sync_q <= {load_sync_q[1:0], load_in};
      done_sync_q <= {done_sync_q[1:0], done_in};
    end
  end

  assign load_rise = load_sync_q[1] & ~load_sync_q[2];
  assign load_fall = ~load_sync_q[1] & load_sync_q[2];
  assign done_rise = done_sync_q[1] & ~done_sync_q[2];

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    capture = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: if (load_rise) state_d = S_ARMED;
      S_ARMED: begin
        if (load_fall) begin
          state_d = S_RECV;
          wd_d    = '0;
        end
      end
      S_RECV: begin
        wd_d = wd_q + WW'(1);
        // A fresh load restarts the transfer even if done or the watchdog fire together.
        if (load_rise)            state_d = S_ARMED;
        else if (done_rise)       state_d = S_CAPTURE;
        else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

`ifdef QUAD_ZERO_DROP_EN
  assign zero_pkt = (pkt_in == '0);
`else
  assign zero_pkt = 1'b0;
`endif

  assign pop  = (count_q != '0) && quad_ready;
  assign full = (count_q == FULL_CNT);
  assign push = capture && !zero_pkt && (!full || pop);
  assign drop = capture && !zero_pkt && full && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    cnt_d    = cnt_q;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + 8'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The registered head must bypass memory when the pushed word becomes the new head.
    if (push && (count_q == {{AW{1'b0}}, pop})) head_d = pkt_in;
    else if (count_d != '0)                     head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pkt_in;
  end

  assign ovf_d = drop    ? 1'b1 : (clr_status ? 1'b0 : ovf_q);
  assign tmo_d = tmo_set ? 1'b1 : (clr_status ? 1'b0 : tmo_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef QUAD_ZERO_DROP_EN
  logic zd_q, zd_d;
  assign zd_d = (capture && zero_pkt) ? 1'b1 : (clr_status ? 1'b0 : zd_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) zd_q <= 1'b0;
    else          zd_q <= zd_d;
  end
  assign zero_drop = zd_q;
`endif

  assign quad_valid = (count_q != '0);
  assign quad_data  = head_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;
  assign pkt_count  = cnt_q;

endmodule
